// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready request side and a one-cycle completion pulse.
// Single-cycle ops finish at the accept edge; MUL runs as a WIDTH-step shift-add.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             enable_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [7:0]       opcode_in,
    input  logic [WIDTH-1:0] alu_input1,
    input  logic [WIDTH-1:0] alu_input2,
    output logic             out_valid_out,
    output logic [WIDTH-1:0] alu_output,
    output logic             zero_flag,
    output logic             sign_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             parity_flag,
    output logic             illegal_op_out,
    output logic             busy_out
);
    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h02;
    localparam logic [7:0] OP_EQ   = 8'h03;
    localparam logic [7:0] OP_GT   = 8'h04;
    localparam logic [7:0] OP_ADDI = 8'h09;
    localparam logic [7:0] OP_SUBI = 8'h0A;
    localparam logic [7:0] OP_MOV  = 8'h0B;

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH:0]     ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_ACC = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;

    state_t             r_state;
    logic               r_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero, r_sign, r_carry, r_overflow, r_parity, r_illegal;
    logic [WIDTH:0]     r_mcand;
    logic [WIDTH:0]     r_mplier;
    logic               r_mulSign;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_count;

    logic [WIDTH:0]     w_addExt, w_subExt, w_extA, w_extB, w_absA, w_absB;
    logic [WIDTH-1:0]   w_opResult, w_doneResult;
    logic               w_opCarry, w_opOverflow, w_opIllegal;
    logic [2*WIDTH-1:0] w_addend, w_product;
    logic [WIDTH:0]     w_prodHigh;
    logic               w_mulOverflow;
    logic               w_doneCarry, w_doneOverflow, w_doneIllegal;
    logic               w_complete;

    assign in_ready_out  = (r_state == IDLE) & enable_in & ~reset_in;
    assign out_valid_out = r_valid & enable_in;
    assign busy_out      = (r_state != IDLE);

    assign alu_output     = r_result;
    assign zero_flag      = r_zero;
    assign sign_flag      = r_sign;
    assign carry_flag     = r_carry;
    assign overflow_flag  = r_overflow;
    assign parity_flag    = r_parity;
    assign illegal_op_out = r_illegal;

    assign w_addExt = {1'b0, alu_input1} + {1'b0, alu_input2};
    assign w_subExt = {1'b0, alu_input1} - {1'b0, alu_input2};

    // Magnitudes use one extra bit so that the most negative operand does not wrap.
    assign w_extA = {alu_input1[MSB], alu_input1};
    assign w_extB = {alu_input2[MSB], alu_input2};
    assign w_absA = alu_input1[MSB] ? ((~w_extA) + ONE_EXT) : w_extA;
    assign w_absB = alu_input2[MSB] ? ((~w_extB) + ONE_EXT) : w_extB;

    assign w_addend      = {{(WIDTH-1){1'b0}}, r_mcand} << r_count;
    assign w_product     = r_mulSign ? ((~r_acc) + ONE_ACC) : r_acc;
    assign w_prodHigh    = w_product[2*WIDTH-1:WIDTH-1];
    assign w_mulOverflow = ~((&w_prodHigh) | ~(|w_prodHigh));

    always_comb begin
        w_opResult   = '0;
        w_opCarry    = 1'b0;
        w_opOverflow = 1'b0;
        w_opIllegal  = 1'b0;
        case (opcode_in)
            OP_ADD, OP_ADDI: begin
                w_opResult   = w_addExt[WIDTH-1:0];
                w_opCarry    = w_addExt[WIDTH];
                w_opOverflow = (alu_input1[MSB] == alu_input2[MSB]) &&
                               (w_addExt[MSB] != alu_input1[MSB]);
            end
            OP_SUB, OP_SUBI: begin
                w_opResult   = w_subExt[WIDTH-1:0];
                w_opCarry    = w_subExt[WIDTH];
                w_opOverflow = (alu_input1[MSB] != alu_input2[MSB]) &&
                               (w_subExt[MSB] != alu_input1[MSB]);
            end
            OP_EQ:  w_opResult = {{(WIDTH-1){1'b0}}, (alu_input1 == alu_input2)};
            OP_GT:  w_opResult = {{(WIDTH-1){1'b0}}, ($signed(alu_input1) > $signed(alu_input2))};
            OP_MOV: w_opResult = alu_input1;
            OP_MUL: w_opResult = '0;
            default: w_opIllegal = 1'b1;
        endcase
    end

    // A completion is either a non-MUL accept in IDLE or the single MUL_DONE cycle.
    always_comb begin
        w_complete = 1'b0;
        if (enable_in && !reset_in) begin
            if (r_state == MUL_DONE)
                w_complete = 1'b1;
            else if (r_state == IDLE && in_valid_in && opcode_in != OP_MUL)
                w_complete = 1'b1;
        end
    end

    assign w_doneResult   = (r_state == MUL_DONE) ? w_product[WIDTH-1:0] : w_opResult;
    assign w_doneCarry    = (r_state == MUL_DONE) ? w_mulOverflow : w_opCarry;
    assign w_doneOverflow = (r_state == MUL_DONE) ? w_mulOverflow : w_opOverflow;
    assign w_doneIllegal  = (r_state == MUL_DONE) ? 1'b0 : w_opIllegal;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_mulSign <= 1'b0;
            r_acc     <= '0;
            r_count   <= '0;
        end else if (enable_in) begin
            r_valid <= w_complete;
            case (r_state)
                IDLE: begin
                    if (in_valid_in && opcode_in == OP_MUL) begin
                        r_mcand   <= w_absA;
                        r_mplier  <= w_absB;
                        r_mulSign <= alu_input1[MSB] ^ alu_input2[MSB];
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_state   <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (r_mplier[0])
                        r_acc <= r_acc + w_addend;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(WIDTH - 1))
                        r_state <= MUL_DONE;
                end
                MUL_DONE: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_sign     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_parity   <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_complete) begin
            r_result   <= w_doneResult;
            r_zero     <= (w_doneResult == '0);
            r_sign     <= w_doneResult[MSB];
            r_carry    <= w_doneCarry;
            r_overflow <= w_doneOverflow;
            r_parity   <= ^w_doneResult;
            r_illegal  <= w_doneIllegal;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal results, then random traffic
// checked every cycle against an arithmetic model of the ALU.
module tb_alu_seq;
    localparam int W = 8;

    logic         clock_in = 1'b0;
    logic         reset_in, enable_in, in_valid_in;
    logic [7:0]   opcode_in;
    logic [W-1:0] alu_input1, alu_input2;
    logic         in_ready_out, out_valid_out;
    logic [W-1:0] alu_output;
    logic         zero_flag, sign_flag, carry_flag, overflow_flag, parity_flag;
    logic         illegal_op_out, busy_out;

    int errors = 0;
    int checks = 0;
    bit checkOn = 1'b0;

    alu_seq #(.WIDTH(W)) dut (
        .clock_in(clock_in), .reset_in(reset_in), .enable_in(enable_in),
        .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
        .opcode_in(opcode_in), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .out_valid_out(out_valid_out), .alu_output(alu_output),
        .zero_flag(zero_flag), .sign_flag(sign_flag), .carry_flag(carry_flag),
        .overflow_flag(overflow_flag), .parity_flag(parity_flag),
        .illegal_op_out(illegal_op_out), .busy_out(busy_out)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [W-1:0] res;
        logic z, s, c, v, p, ill;
    } expT;

    // Results from plain signed/unsigned integer arithmetic.
    function automatic expT compute(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        expT e;
        longint sa, sb, ua, ub, r, lim;
        bit outRange;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        lim = 1;
        lim = lim << (W - 1);
        r = 0;
        e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0;
        case (op)
            8'h00, 8'h09: begin
                r = sa + sb;
                e.c = ((ua + ub) >> W) != 0;
                e.v = (r < -lim) || (r > lim - 1);
            end
            8'h01, 8'h0A: begin
                r = sa - sb;
                e.c = ua < ub;
                e.v = (r < -lim) || (r > lim - 1);
            end
            8'h02: begin
                r = sa * sb;
                outRange = (r < -lim) || (r > lim - 1);
                e.c = outRange;
                e.v = outRange;
            end
            8'h03: r = (sa == sb) ? 1 : 0;
            8'h04: r = (sa > sb) ? 1 : 0;
            8'h0B: r = sa;
            default: e.ill = 1'b1;
        endcase
        e.res = r[W-1:0];
        e.z = (e.res == '0);
        e.s = e.res[W-1];
        e.p = ^e.res;
        return e;
    endfunction

    int  mLeft;
    bit  mValid;
    expT mOut, mMulPend;

    always @(posedge clock_in) begin
        bit done;
        if (reset_in) begin
            mLeft = 0;
            mValid = 1'b0;
            mOut = '{default: '0};
            mOut.z = 1'b1;
        end else if (enable_in) begin
            done = 1'b0;
            if (mLeft > 0) begin
                mLeft--;
                if (mLeft == 0) begin
                    mOut = mMulPend;
                    done = 1'b1;
                end
            end else if (in_valid_in) begin
                if (opcode_in == 8'h02) begin
                    mMulPend = compute(opcode_in, alu_input1, alu_input2);
                    mLeft = W + 1;
                end else begin
                    mOut = compute(opcode_in, alu_input1, alu_input2);
                    done = 1'b1;
                end
            end
            mValid = done;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock_in) begin
        if (checkOn) begin
            check("ready",    in_ready_out,   (mLeft == 0) && enable_in && !reset_in);
            check("busy",     busy_out,       mLeft > 0);
            check("valid",    out_valid_out,  mValid && enable_in);
            check("result",   alu_output,     mOut.res);
            check("zero",     zero_flag,      mOut.z);
            check("sign",     sign_flag,      mOut.s);
            check("carry",    carry_flag,     mOut.c);
            check("overflow", overflow_flag,  mOut.v);
            check("parity",   parity_flag,    mOut.p);
            check("illegal",  illegal_op_out, mOut.ill);
        end
    end

    task automatic applyStimulus(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clock_in); #1;
        in_valid_in = 1'b1;
        opcode_in = op;
        alu_input1 = a;
        alu_input2 = b;
        @(posedge clock_in); #1;
        in_valid_in = 1'b0;
    endtask

    task automatic waitValid(input int maxCycles, output int latency, output int readyLow);
        latency = -1;
        readyLow = 0;
        for (int i = 1; i <= maxCycles; i++) begin
            @(negedge clock_in);
            if (out_valid_out === 1'b1) begin
                latency = i;
                return;
            end
            if (in_ready_out === 1'b0) readyLow++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] res, input logic z, input logic s,
                               input logic c, input logic v, input logic p, input logic ill);
        check({name, ".valid"}, out_valid_out, 1'b1);
        check({name, ".res"},   alu_output,    res);
        check({name, ".z"},     zero_flag,     z);
        check({name, ".s"},     sign_flag,     s);
        check({name, ".c"},     carry_flag,    c);
        check({name, ".v"},     overflow_flag, v);
        check({name, ".p"},     parity_flag,   p);
        check({name, ".ill"},   illegal_op_out, ill);
    endtask

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(0, 5))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'h00;
            3: return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat, rl, seen;
        logic [7:0] opTable [8];
        opTable = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h09, 8'h0A, 8'h0B};

        reset_in = 1'b1;
        enable_in = 1'b1;
        in_valid_in = 1'b0;
        opcode_in = 8'h00;
        alu_input1 = '0;
        alu_input2 = '0;
        repeat (2) @(posedge clock_in);
        #1 reset_in = 1'b0;
        checkOn = 1'b1;
        @(negedge clock_in);
        check("rst.ready", in_ready_out, 1'b1);
        check("rst.res",   alu_output,   8'h00);
        check("rst.zero",  zero_flag,    1'b1);
        check("rst.valid", out_valid_out, 1'b0);

        applyStimulus(8'h00, 8'd100, 8'd50);
        waitValid(5, lat, rl);
        check("add.lat", lat, 1);
        checkOutput("add", 8'h96, 0, 1, 0, 1, 0, 0);

        @(posedge clock_in); #1;
        in_valid_in = 1'b1; opcode_in = 8'h01; alu_input1 = 8'd5; alu_input2 = 8'd7;
        @(posedge clock_in); #1;
        opcode_in = 8'h04; alu_input1 = 8'd3; alu_input2 = 8'hFC;
        @(negedge clock_in);
        checkOutput("sub", 8'hFE, 0, 1, 1, 0, 1, 0);
        @(posedge clock_in); #1;
        in_valid_in = 1'b0;
        @(negedge clock_in);
        checkOutput("gt", 8'h01, 0, 0, 0, 0, 1, 0);

        applyStimulus(8'h02, 8'hFD, 8'd5);
        waitValid(20, lat, rl);
        check("mul1.lat", lat, W + 2);
        check("mul1.readyLow", rl, W + 1);
        checkOutput("mul1", 8'hF1, 0, 1, 0, 0, 1, 0);

        applyStimulus(8'h02, 8'd16, 8'd16);
        waitValid(20, lat, rl);
        check("mul2.lat", lat, W + 2);
        checkOutput("mul2", 8'h00, 1, 0, 1, 1, 0, 0);

        applyStimulus(8'h02, 8'h80, 8'd1);
        waitValid(20, lat, rl);
        checkOutput("mul3", 8'h80, 0, 1, 0, 0, 1, 0);

        // Abort a multiply with a one-cycle reset partway through.
        applyStimulus(8'h02, 8'd7, 8'd7);
        repeat (3) @(posedge clock_in);
        #1 reset_in = 1'b1;
        @(posedge clock_in);
        #1 reset_in = 1'b0;
        @(negedge clock_in);
        check("abort.ready", in_ready_out, 1'b1);
        check("abort.res",   alu_output,   8'h00);
        check("abort.zero",  zero_flag,    1'b1);
        check("abort.busy",  busy_out,     1'b0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid_out !== 1'b0) seen++;
            @(negedge clock_in);
        end
        check("abort.noValid", seen, 0);

        applyStimulus(8'h02, 8'd12, 8'd11);
        fork
            waitValid(30, lat, rl);
            begin
                repeat (2) @(posedge clock_in);
                #1 enable_in = 1'b0;
                repeat (3) @(posedge clock_in);
                #1 enable_in = 1'b1;
            end
        join
        check("stall.lat", lat, W + 5);
        checkOutput("stall", 8'h84, 0, 1, 1, 1, 0, 0);

        applyStimulus(8'hFF, 8'd9, 8'd9);
        waitValid(5, lat, rl);
        checkOutput("illegal", 8'h00, 1, 0, 0, 0, 0, 1);
        applyStimulus(8'h00, 8'd1, 8'd1);
        waitValid(5, lat, rl);
        checkOutput("add2", 8'h02, 0, 0, 0, 0, 1, 0);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clock_in); #1;
            reset_in    = ($urandom_range(0, 199) == 0);
            enable_in   = ($urandom_range(0, 9) != 0);
            in_valid_in = ($urandom_range(0, 3) != 0);
            opcode_in   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : opTable[$urandom_range(0, 7)];
            alu_input1  = randOperand();
            alu_input2  = randOperand();
        end
        @(posedge clock_in); #1;
        reset_in = 1'b0;
        enable_in = 1'b1;
        in_valid_in = 1'b0;
        repeat (20) @(posedge clock_in);
        @(negedge clock_in);
        checkOn = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
